// File: rtl/serial_frame_rx.sv
// Serial frame receiver: start(0), DATA_W data bits LSB-first, optional even parity, stop(1).
// Define SERIAL_FRAME_RX_PARITY_EN to add the parity bit and the parity_err output.
module serial_frame_rx #(
    parameter int DATA_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sin_en,
    input  logic              sin,
    output logic [DATA_W-1:0] data_out,
    output logic              valid,
    output logic              busy,
    output logic              frame_err
`ifdef SERIAL_FRAME_RX_PARITY_EN
    ,
    output logic              parity_err
`endif
);

    localparam int CNT_W = $clog2(DATA_W + 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_DATA   = 3'd1;
`ifdef SERIAL_FRAME_RX_PARITY_EN
    localparam logic [2:0] S_PARITY = 3'd2;
`endif
    localparam logic [2:0] S_STOP   = 3'd3;
    localparam logic [2:0] S_HUNT   = 3'd4;

    logic [2:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q,   cnt_d;
    logic [DATA_W-1:0] buf_q,   buf_d;
    logic [DATA_W-1:0] dout_q,  dout_d;
    logic              valid_q, valid_d;
    logic              ferr_q,  ferr_d;
`ifdef SERIAL_FRAME_RX_PARITY_EN
    logic              par_q,   par_d;
    logic              perr_q,  perr_d;
`endif

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        state_d = state_q;
        cnt_d   = cnt_q;
        buf_d   = buf_q;
        dout_d  = dout_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
`ifdef SERIAL_FRAME_RX_PARITY_EN
        par_d   = par_q;
        perr_d  = 1'b0;
`endif
        if (sin_en) begin
            case (state_q)
                S_IDLE: begin
                    if (!sin) begin
                        state_d = S_DATA;
                        cnt_d   = '0;
                    end
                end
                S_DATA: begin
                    buf_d = {sin, buf_q[DATA_W-1:1]};
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(DATA_W - 1)) begin
`ifdef SERIAL_FRAME_RX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end
                end
`ifdef SERIAL_FRAME_RX_PARITY_EN
                S_PARITY: begin
                    par_d   = sin;
                    state_d = S_STOP;
                end
`endif
                S_STOP: begin
                    if (sin) begin
                        dout_d  = buf_q;
                        valid_d = 1'b1;
`ifdef SERIAL_FRAME_RX_PARITY_EN
                        perr_d  = ^{buf_q, par_q};
`endif
                        state_d = S_IDLE;
                    end else begin
                        // A bad stop bit means we lost framing; wait for idle line before re-arming.
                        ferr_d  = 1'b1;
                        state_d = S_HUNT;
                    end
                end
                S_HUNT: begin
                    if (sin) begin
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            buf_q   <= '0;
            dout_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
`ifdef SERIAL_FRAME_RX_PARITY_EN
            par_q   <= 1'b0;
            perr_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            buf_q   <= buf_d;
            dout_q  <= dout_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
`ifdef SERIAL_FRAME_RX_PARITY_EN
            par_q   <= par_d;
            perr_q  <= perr_d;
`endif
        end
    end

    assign data_out   = dout_q;
    assign valid      = valid_q;
    assign frame_err  = ferr_q;
    assign busy       = (state_q != S_IDLE);
`ifdef SERIAL_FRAME_RX_PARITY_EN
    assign parity_err = perr_q;
`endif

endmodule
